// File: rtl/rd_data_arbiter_if.sv
// Read-data arbiter bus: source data/enables, mask and
// collision-clear controls in, arbitrated read data and status out.
interface rd_data_arbiter_if #(
    parameter int DW  = 8,
    parameter int NCH = 8,
    parameter int CW  = 8
);
    logic              rd_i;
    logic [NCH*DW-1:0] src_dat_i;
    logic [NCH-1:0]    src_e_i;
    logic              mask_we_i;
    logic [NCH-1:0]    mask_d_i;
    logic              clr_i;
    logic [DW-1:0]     dat_o;
    logic              hit_o;
    logic [3:0]        sel_o;
    logic              coll_o;
    logic              coll_flag_o;
    logic [CW-1:0]     coll_cnt_o;
    logic [NCH-1:0]    mask_o;

    modport master (
        output rd_i, src_dat_i, src_e_i,
        output mask_we_i, mask_d_i, clr_i,
        input  dat_o, hit_o, sel_o,
        input  coll_o, coll_flag_o, coll_cnt_o, mask_o
    );

    modport slave (
        input  rd_i, src_dat_i, src_e_i,
        input  mask_we_i, mask_d_i, clr_i,
        output dat_o, hit_o, sel_o,
        output coll_o, coll_flag_o, coll_cnt_o, mask_o
    );
endinterface

// File: rtl/rd_data_arbiter.sv
// Registered fixed-priority read-data arbiter (lowest channel wins)
// with enable mask, collision pulse, sticky flag and saturating count.
module rd_data_arbiter #(
    parameter int            DW       = 8,
    parameter int            NCH      = 8,
    parameter logic [DW-1:0] IDLE_VAL = {DW{1'b1}},
    parameter int            CW       = 8
) (
    input logic               clock_i,
    input logic               reset_i,
    rd_data_arbiter_if.slave  bus
);
    localparam logic [NCH-1:0] ACT_ONE = NCH'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

    logic [NCH-1:0] act;
    logic           any_act;
    logic           multi;
    logic           coll;
    logic [3:0]     win_sel;
    logic [DW-1:0]  win_dat;

    logic [DW-1:0]  dat_q;
    logic           hit_q;
    logic [3:0]     sel_q;
    logic           coll_q;
    logic           flag_q;
    logic [CW-1:0]  cnt_q;
    logic [NCH-1:0] mask_q;

    assign act     = bus.src_e_i & mask_q;
    assign any_act = |act;
    assign multi   = |(act & (act - ACT_ONE));
    assign coll    = bus.rd_i & multi;

    // Priority encode: scan high to low so the lowest set index wins.
    always_comb begin
        win_sel = '0;
        win_dat = IDLE_VAL;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (act[i]) begin
                win_sel = 4'(i);
                win_dat = bus.src_dat_i[i*DW +: DW];
            end
        end
    end

    // Register read result, mask and collision bookkeeping.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            dat_q  <= IDLE_VAL;
            hit_q  <= 1'b0;
            sel_q  <= '0;
            coll_q <= 1'b0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
            mask_q <= '1;
        end else begin
            if (bus.mask_we_i) begin
                mask_q <= bus.mask_d_i;
            end
            if (bus.rd_i) begin
                dat_q <= win_dat;
                sel_q <= win_sel;
                hit_q <= any_act;
            end
            coll_q <= coll;
            if (coll) begin
                flag_q <= 1'b1;
                if (bus.clr_i) begin
                    cnt_q <= CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end else if (bus.clr_i) begin
                flag_q <= 1'b0;
                cnt_q  <= '0;
            end
        end
    end

    assign bus.dat_o       = dat_q;
    assign bus.hit_o       = hit_q;
    assign bus.sel_o       = sel_q;
    assign bus.coll_o      = coll_q;
    assign bus.coll_flag_o = flag_q;
    assign bus.coll_cnt_o  = cnt_q;
    assign bus.mask_o      = mask_q;
endmodule

// File: tb/tb_rd_data_arbiter.sv
// Bench for rd_data_arbiter: vector table, directed corner sequences
// and randomized traffic against a behavioural reference model.
module tb_rd_data_arbiter;
    localparam int DW  = 8;
    localparam int NCH = 8;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    rd_data_arbiter_if #(.DW(DW), .NCH(NCH), .CW(CW)) bus ();

    rd_data_arbiter #(
        .DW(DW), .NCH(NCH), .IDLE_VAL({DW{1'b1}}), .CW(CW)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ch_dat [NCH];

    // reference model state
    int m_dat, m_sel, m_hit, m_coll, m_flag, m_cnt, m_mask;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model(input bit rd, input int e, input bit we,
                         input int d, input bit clr, input bit rst);
        int a;
        int k;
        if (rst) begin
            m_dat = 255; m_hit = 0; m_sel = 0;
            m_coll = 0; m_flag = 0; m_cnt = 0; m_mask = 255;
            return;
        end
        a = e & m_mask;
        if (rd) begin
            if (a == 0) begin
                m_dat = 255; m_sel = 0; m_hit = 0;
            end else begin
                k = 0;
                while (((a >> k) & 1) == 0) k++;
                m_dat = int'(ch_dat[k]); m_sel = k; m_hit = 1;
            end
        end
        m_coll = (rd && $countones(a) > 1) ? 1 : 0;
        if (clr) begin
            m_cnt = 0; m_flag = 0;
        end
        if (m_coll != 0) begin
            m_flag = 1;
            if (m_cnt < CMAX) m_cnt++;
        end
        if (we) m_mask = d;
    endtask

    task automatic cycle(input bit rd, input int e, input bit we,
                         input int d, input bit clr, input bit rst);
        reset_i       = rst;
        bus.rd_i      = rd;
        bus.src_e_i   = NCH'(e);
        bus.mask_we_i = we;
        bus.mask_d_i  = NCH'(d);
        bus.clr_i     = clr;
        for (int k = 0; k < NCH; k++) bus.src_dat_i[k*DW +: DW] = ch_dat[k];
        model(rd, e, we, d, clr, rst);
        @(posedge clock_i);
        #1;
        chk("m_dat", int'(bus.dat_o), m_dat);
        chk("m_hit", int'(bus.hit_o), m_hit);
        chk("m_sel", int'(bus.sel_o), m_sel);
        chk("m_coll", int'(bus.coll_o), m_coll);
        chk("m_flag", int'(bus.coll_flag_o), m_flag);
        chk("m_cnt", int'(bus.coll_cnt_o), m_cnt);
        chk("m_mask", int'(bus.mask_o), m_mask);
    endtask

    typedef struct {
        bit rd; int e; bit we; int d; bit clr;
        int dat; int sel; int hit; int coll; int flag; int cnt; int mask;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1, 'h04, 0, 'h00, 0, 'h22, 2, 1, 0, 0, 0, 'hFF};
        vt[1]  = '{0, 'hFF, 0, 'h00, 0, 'h22, 2, 1, 0, 0, 0, 'hFF};
        vt[2]  = '{1, 'h28, 0, 'h00, 0, 'h33, 3, 1, 1, 1, 1, 'hFF};
        vt[3]  = '{1, 'h00, 0, 'h00, 0, 'hFF, 0, 0, 0, 1, 1, 'hFF};
        vt[4]  = '{1, 'h81, 0, 'h00, 0, 'h00, 0, 1, 1, 1, 2, 'hFF};
        vt[5]  = '{1, 'h80, 0, 'h00, 0, 'h77, 7, 1, 0, 1, 2, 'hFF};
        vt[6]  = '{1, 'h28, 1, 'hF7, 0, 'h33, 3, 1, 1, 1, 3, 'hF7};
        vt[7]  = '{1, 'h28, 0, 'h00, 0, 'h55, 5, 1, 0, 1, 3, 'hF7};
        vt[8]  = '{1, 'h08, 0, 'h00, 0, 'hFF, 0, 0, 0, 1, 3, 'hF7};
        vt[9]  = '{0, 'h28, 0, 'h00, 1, 'hFF, 0, 0, 0, 0, 0, 'hF7};
        vt[10] = '{1, 'hFF, 1, 'hFF, 1, 'h00, 0, 1, 1, 1, 1, 'hFF};
        vt[11] = '{0, 'h00, 0, 'h00, 0, 'h00, 0, 1, 0, 1, 1, 'hFF};

        for (int k = 0; k < NCH; k++) ch_dat[k] = DW'(k * 'h11);
        bus.rd_i = 0; bus.src_e_i = '0; bus.mask_we_i = 0;
        bus.mask_d_i = '0; bus.clr_i = 0; bus.src_dat_i = '0;

        // reset then idle
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("idle_dat", int'(bus.dat_o), 'hFF);
        chk("idle_hit", int'(bus.hit_o), 0);
        chk("idle_mask", int'(bus.mask_o), 'hFF);
        chk("idle_cnt", int'(bus.coll_cnt_o), 0);

        // vector table
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].rd, vt[i].e, vt[i].we, vt[i].d, vt[i].clr, 0);
            chk($sformatf("v%0d_dat", i), int'(bus.dat_o), vt[i].dat);
            chk($sformatf("v%0d_sel", i), int'(bus.sel_o), vt[i].sel);
            chk($sformatf("v%0d_hit", i), int'(bus.hit_o), vt[i].hit);
            chk($sformatf("v%0d_coll", i), int'(bus.coll_o), vt[i].coll);
            chk($sformatf("v%0d_flag", i),
                int'(bus.coll_flag_o), vt[i].flag);
            chk($sformatf("v%0d_cnt", i),
                int'(bus.coll_cnt_o), vt[i].cnt);
            chk($sformatf("v%0d_mask", i), int'(bus.mask_o), vt[i].mask);
        end

        // single read then hold while source changes
        ch_dat[2] = 8'hA5;
        cycle(1, 'h04, 0, 0, 0, 0);
        chk("rd2_dat", int'(bus.dat_o), 'hA5);
        chk("rd2_sel", int'(bus.sel_o), 2);
        chk("rd2_coll", int'(bus.coll_o), 0);
        ch_dat[2] = 8'h00;
        cycle(0, 'h04, 0, 0, 0, 0);
        chk("hold_dat", int'(bus.dat_o), 'hA5);

        // saturation over 300 colliding reads
        ch_dat[3] = 8'h11;
        ch_dat[5] = 8'h22;
        cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(1, 'h28, 0, 0, 0, 0);
            if (i == 99) chk("cnt_100", int'(bus.coll_cnt_o), 100);
        end
        chk("sat_cnt", int'(bus.coll_cnt_o), 255);
        chk("sat_dat", int'(bus.dat_o), 'h11);
        chk("sat_coll", int'(bus.coll_o), 1);
        cycle(1, 'h28, 0, 0, 1, 0);
        chk("clrcol_cnt", int'(bus.coll_cnt_o), 1);
        chk("clrcol_flag", int'(bus.coll_flag_o), 1);
        chk("clrcol_coll", int'(bus.coll_o), 1);

        // reset during a colliding read
        cycle(1, 'h28, 1, 'h0F, 0, 1);
        chk("rst_dat", int'(bus.dat_o), 'hFF);
        chk("rst_hit", int'(bus.hit_o), 0);
        chk("rst_sel", int'(bus.sel_o), 0);
        chk("rst_coll", int'(bus.coll_o), 0);
        chk("rst_flag", int'(bus.coll_flag_o), 0);
        chk("rst_cnt", int'(bus.coll_cnt_o), 0);
        chk("rst_mask", int'(bus.mask_o), 'hFF);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int e;
            for (int k = 0; k < NCH; k++) ch_dat[k] = DW'($urandom);
            case ($urandom_range(0, 3))
                0: e = 0;
                1: e = 1 << $urandom_range(0, NCH - 1);
                default: e = $urandom_range(0, 255);
            endcase
            cycle($urandom_range(0, 3) != 0, e,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 255),
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rd_data_arbiter.md
Name: rd_data_arbiter

Overview:
Parametrised, registered read-data arbiter that returns CPU read data from NCH memory/IO sources onto a single DW-bit bus. Fixed priority: lowest channel index wins. Adds a per-channel enable mask, collision detection with a saturating counter, a sticky flag, and hold-last-value behaviour between reads. Sits between the address decoders / peripheral data outputs and the CPU data-in port.

Parameters:
DW, 8, data width in bits
NCH, 8, number of source channels (2..16)
IDLE_VAL, {DW{1'b1}}, value driven when a read selects no source (floating-bus emulation)
CW, 8, collision counter width in bits

Ports:
clock_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous reset, active-high
rd_i  in  1  CPU read strobe; sampled every clock
src_dat_i  in  NCH*DW  flattened source data; channel k occupies bits [k*DW +: DW]
src_e_i  in  NCH  per-channel select/enable from address decode
mask_we_i  in  1  mask write strobe
mask_d_i  in  NCH  new mask value (1 = channel allowed)
clr_i  in  1  clear collision counter and sticky flag
dat_o  out  DW  registered read data
hit_o  out  1  last read matched a channel
sel_o  out  4  index of winning channel from last read
coll_o  out  1  one-cycle pulse, collision on this read
coll_flag_o  out  1  sticky collision flag
coll_cnt_o  out  CW  saturating collision count
mask_o  out  NCH  current mask

Behaviour:
- Reset (synchronous, active-high on clock_i edge), values:
  - dat_o = IDLE_VAL; hit_o = 0; sel_o = 0
  - coll_o = 0; coll_flag_o = 0; coll_cnt_o = 0
  - mask_o = all ones
- Reset mid-read: reset takes priority over all other updates.
- Active set: act = src_e_i & mask_o. Masking uses the registered mask_o.
- Mask write (mask_we_i = 1): mask_o <= mask_d_i on the next edge. A read in the same cycle uses the old mask.
- Read cycle (rd_i = 1), outputs update at the next edge (latency 1):
  - act != 0: dat_o <= data of the lowest set index in act; sel_o <= that index; hit_o <= 1.
  - act == 0: dat_o <= IDLE_VAL; sel_o <= 0; hit_o <= 0.
- Non-read cycle (rd_i = 0):
  - dat_o, sel_o and hit_o hold their values.
  - coll_o <= 0.
- Collision (rd_i = 1 and more than one bit set in act):
  - coll_o <= 1 for exactly one cycle per colliding read cycle.
  - coll_flag_o <= 1.
  - coll_cnt_o increments by 1, saturating at 2^CW-1 (never wraps).
  - Arbitration result is still the lowest index.
- No collision on a read: coll_o <= 0.
- Clear (clr_i = 1): coll_flag_o <= 0; coll_cnt_o <= 0.
- clr_i in the same cycle as a collision: the collision wins. Result: coll_cnt_o = 1, coll_flag_o = 1, coll_o = 1.
- Consecutive read cycles with rd_i held high: each cycle is an independent arbitration. A collision on every cycle counts once per cycle.
- Fully masked channels never cause a collision and never win.
- sel_o is zero-extended to 4 bits regardless of NCH.
- Implementation: a loop-based priority encoder plus a popcount>1 (or act & (act-1) != 0) detector, all registered. No combinational path from inputs to outputs.

Test Plan:
- Reset then idle (rd_i = 0) -> dat_o = 8'hFF, hit_o = 0, mask_o = 8'hFF, coll_cnt_o = 0.
- rd_i = 1, src_e_i = 8'b0000_0100, ch2 data = 8'hA5 -> one cycle later dat_o = 8'hA5, sel_o = 2, hit_o = 1, coll_o = 0. Drop rd_i and change ch2 data to 8'h00 -> dat_o holds 8'hA5.
- rd_i = 1, src_e_i = 8'b0010_1000, ch3 = 8'h11, ch5 = 8'h22 -> dat_o = 8'h11, sel_o = 3, coll_o pulses once, coll_cnt_o = 1, coll_flag_o = 1.
- Write mask 8'b1111_0111, same src_e_i as above, read -> mask applies from the next cycle: dat_o = 8'h22, sel_o = 5, no collision. Read with only ch3 enabled -> dat_o = 8'hFF, hit_o = 0.
- 300 consecutive colliding read cycles with CW = 8 -> coll_cnt_o saturates at 255. Then clr_i together with a colliding read -> coll_cnt_o = 1, coll_flag_o = 1.
- Assert reset_i during a colliding read -> next cycle all outputs are at their reset values. No coll_o pulse and no count increment.
